six_lane_stimulus_sequencer: RTL

- Programmable stimulus source that directly drives the six 7-bit input lanes of the 6x6 scalable module (M0) under test.
- Holds a table of up to DEPTH lane vectors, each with a dwell count, and plays them back in order, once or looping.
- Replaces hand-written delay chains, so flow-tracking runs on M0 get repeatable, cycle-exact input sequences.

---
 rtl/six_lane_stimulus_sequencer_pkg.sv | 32 +++
 rtl/six_lane_stimulus_sequencer_stim_table.sv | 35 +++
 rtl/six_lane_stimulus_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/six_lane_stimulus_sequencer_pkg.sv
// Shared definitions for the six-lane stimulus sequencer.
//   - Geometry constants (lanes, lane width, table depth, dwell width)
//   - FSM state encoding (IDLE / PLAY / FIN)
//   - Table entry record {vec, dwell}
//   - lane_slice(): extracts lane k from a packed lane vector
package six_lane_stimulus_sequencer_pkg;

    localparam int LANES   = 6;
    localparam int WIDTH   = 7;
    localparam int DEPTH   = 8;
    localparam int DWELL_W = 4;
    localparam int AW      = $clog2(DEPTH);
    localparam int VEC_W   = LANES * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [VEC_W-1:0]   vec;
        logic [DWELL_W-1:0] dwell;
    } entry_t;

    // lane_k occupies vec[k*WIDTH +: WIDTH]
    function automatic logic [WIDTH-1:0] lane_slice(input logic [VEC_W-1:0] vec,
                                                    input int unsigned      k);
        return vec[k*WIDTH +: WIDTH];
    endfunction

endpackage

// File: rtl/six_lane_stimulus_sequencer_stim_table.sv
// Stimulus table: DEPTH entries of {lane vector, dwell count}.
// Synchronous write, asynchronous (combinational) read, asynchronous clear.
// Ports:
//   clk, rst_n  - clock, async active-low reset (clears every entry)
//   we, waddr   - write strobe and entry index
//   wdata       - entry written at the clock edge
//   raddr       - entry index to read
//   rdata       - contents of entry raddr
module six_lane_stimulus_sequencer_stim_table
    import six_lane_stimulus_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/six_lane_stimulus_sequencer.sv
// Six-lane stimulus sequencer: plays a programmed table of lane vectors onto
// lane_0..lane_5, holding each step for dwell+1 cycles, once or looping.
//
//   state | meaning
//   IDLE  | lanes 0, table writable, waiting for start
//   PLAY  | stepping through entries 0..last (busy=1)
//   FIN   | one-cycle done pulse after a non-looping pass
//
// Ports:
//   clk, rst_n               - clock, async active-low reset
//   cfg_we/addr/vec/dwell    - table write (honoured only in IDLE)
//   cfg_last, loop_en        - final step index / loop mode, latched on start
//   start, stop              - begin playback / abort (stop wins)
//   lane_0..lane_5           - registered lane values
//   step_strobe, step_idx    - first-cycle-of-step pulse, current step
//   busy, done               - PLAY indicator, completion pulse
module six_lane_stimulus_sequencer
    import six_lane_stimulus_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [VEC_W-1:0]   cfg_vec,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [AW-1:0]      cfg_last,
    input  logic               start,
    input  logic               loop_en,
    input  logic               stop,
    output logic [WIDTH-1:0]   lane_0,
    output logic [WIDTH-1:0]   lane_1,
    output logic [WIDTH-1:0]   lane_2,
    output logic [WIDTH-1:0]   lane_3,
    output logic [WIDTH-1:0]   lane_4,
    output logic [WIDTH-1:0]   lane_5,
    output logic               step_strobe,
    output logic [AW-1:0]      step_idx,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [VEC_W-1:0]   lanes_q, lanes_d;
    logic               strobe_q, strobe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [AW-1:0]      last_q, last_d;
    logic               loop_q, loop_d;

    logic [AW-1:0]      rd_addr;
    entry_t             rd_entry;
    entry_t             wr_entry;
    logic               tbl_we;

    // The table is frozen for the whole run, FIN included.
    assign tbl_we   = cfg_we && (state_q == ST_IDLE);
    assign wr_entry = '{vec: cfg_vec, dwell: cfg_dwell};

    six_lane_stimulus_sequencer_stim_table u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tbl_we),
        .waddr (cfg_addr),
        .wdata (wr_entry),
        .raddr (rd_addr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            lanes_q  <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            last_q   <= '0;
            loop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            lanes_q  <= lanes_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            last_q   <= last_d;
            loop_q   <= loop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        lanes_d  = lanes_q;
        strobe_d = 1'b0;
        last_d   = last_q;
        loop_d   = loop_q;
        rd_addr  = '0;

        case (state_q)
            ST_IDLE: begin
                lanes_d = '0;
                idx_d   = '0;
                if (start && !stop) begin
                    last_d   = cfg_last;
                    loop_d   = loop_en;
                    lanes_d  = rd_entry.vec;
                    cnt_d    = rd_entry.dwell;
                    strobe_d = 1'b1;
                    state_d  = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (stop) begin
                    lanes_d = '0;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    if (idx_q != last_q) begin
                        rd_addr  = idx_q + AW'(1);
                        idx_d    = rd_addr;
                        lanes_d  = rd_entry.vec;
                        cnt_d    = rd_entry.dwell;
                        strobe_d = 1'b1;
                    end else if (loop_q) begin
                        // rd_addr already 0: wrap with no gap cycle
                        idx_d    = '0;
                        lanes_d  = rd_entry.vec;
                        cnt_d    = rd_entry.dwell;
                        strobe_d = 1'b1;
                    end else begin
                        lanes_d = '0;
                        idx_d   = '0;
                        state_d = ST_FIN;
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end

            ST_FIN: begin
                lanes_d = '0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                lanes_d = '0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_PLAY);
        done_d = (state_d == ST_FIN);
    end

    assign lane_0      = lane_slice(lanes_q, 0);
    assign lane_1      = lane_slice(lanes_q, 1);
    assign lane_2      = lane_slice(lanes_q, 2);
    assign lane_3      = lane_slice(lanes_q, 3);
    assign lane_4      = lane_slice(lanes_q, 4);
    assign lane_5      = lane_slice(lanes_q, 5);
    assign step_strobe = strobe_q;
    assign step_idx    = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
